// File: rtl/vm_coin_sched.sv
// vm_coin_sched: dual-slot coin front end for the vending FSM.
// Coins from slots A and B are validated, arbitrated round-robin into a small
// FIFO, issued one at a time to the vending FSM, and the FSM's dispense/change
// flags are stretched into back-to-back motor and hopper pulses.
module vm_coin_sched #(
  parameter int PULSE_CYC  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       coin_a,
  input  logic             coin_a_stb,
  input  logic [1:0]       coin_b,
  input  logic             coin_b_stb,
  output logic             rej_a,
  output logic             rej_b,
  output logic [1:0]       vm_d_in,
  input  logic             vm_d_out,
  input  logic             vm_d_c,
  output logic             motor,
  output logic             hopper,
  output logic             busy,
  output logic [CNT_W-1:0] sale_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_V = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_V   = CW'(1);
  localparam logic [CW-1:0] TWO_V   = CW'(2);
  localparam logic [7:0]    PULSE_V = 8'(PULSE_CYC);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT     = 3'd2,
    DISPENSE = 3'd3,
    CHANGE   = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [1:0]    fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          pref_b_r;   // 0: slot A wins a conflict, 1: slot B wins

  // Enqueue decision
  logic          valid_a_s;
  logic          valid_b_s;
  logic [CW-1:0] free_s;
  logic [1:0]    n_push_s;
  logic [1:0]    wr0_s;
  logic [1:0]    wr1_s;
  logic          lost_a_s;
  logic          lost_b_s;
  logic          flip_s;
  logic          rej_a_s;
  logic          rej_b_s;

  // Sequencer
  state_t        state_r;
  state_t        state_s;
  logic [7:0]    pulse_cnt_r;
  logic [7:0]    pulse_cnt_s;
  logic          chg_pend_r;
  logic          chg_pend_s;
  logic [1:0]    code_s;
  logic          sale_inc_s;
  logic          pop_s;
  logic [1:0]    head_s;

  assign valid_a_s = coin_a_stb && ((coin_a == 2'b01) || (coin_a == 2'b10));
  assign valid_b_s = coin_b_stb && ((coin_b == 2'b01) || (coin_b == 2'b10));

  // Room is judged on the occupancy before this edge; a same-cycle pop does not help.
  assign free_s = DEPTH_V - count_r;

  // Invalid codes and coins that find no room both come back through the slot.
  assign rej_a_s = (coin_a_stb && !valid_a_s) || lost_a_s;
  assign rej_b_s = (coin_b_stb && !valid_b_s) || lost_b_s;

  assign pop_s  = (state_r == IDLE) && (count_r != {CW{1'b0}});
  assign head_s = fifo_mem_r[rd_ptr_r];

  // Arbitrate the two slots into at most two FIFO writes, preferred slot first.
  always_comb begin
    n_push_s = 2'd0;
    wr0_s    = 2'b00;
    wr1_s    = 2'b00;
    lost_a_s = 1'b0;
    lost_b_s = 1'b0;
    flip_s   = 1'b0;
    if (valid_a_s && valid_b_s) begin
      flip_s = 1'b1;
      wr0_s  = pref_b_r ? coin_b : coin_a;
      wr1_s  = pref_b_r ? coin_a : coin_b;
      if (free_s >= TWO_V) begin
        n_push_s = 2'd2;
      end else if (free_s == ONE_V) begin
        n_push_s = 2'd1;
        if (pref_b_r) begin
          lost_a_s = 1'b1;
        end else begin
          lost_b_s = 1'b1;
        end
      end else begin
        lost_a_s = 1'b1;
        lost_b_s = 1'b1;
      end
    end else if (valid_a_s) begin
      wr0_s = coin_a;
      if (free_s != {CW{1'b0}}) begin
        n_push_s = 2'd1;
      end else begin
        lost_a_s = 1'b1;
      end
    end else if (valid_b_s) begin
      wr0_s = coin_b;
      if (free_s != {CW{1'b0}}) begin
        n_push_s = 2'd1;
      end else begin
        lost_b_s = 1'b1;
      end
    end else begin
      n_push_s = 2'd0;
    end
  end

  // FIFO data array; contents need no reset because the pointers define validity.
  always_ff @(posedge Clk) begin
    if (n_push_s != 2'd0) begin
      fifo_mem_r[wr_ptr_r] <= wr0_s;
    end
    if (n_push_s == 2'd2) begin
      fifo_mem_r[wr_ptr_r + AW'(1)] <= wr1_s;
    end
  end

  // FIFO pointers, occupancy and round-robin preference.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      pref_b_r <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_r + AW'(n_push_s);
      rd_ptr_r <= rd_ptr_r + AW'(pop_s);
      count_r  <= count_r + CW'(n_push_s) - CW'(pop_s);
      if (flip_s) begin
        pref_b_r <= ~pref_b_r;
      end
    end
  end

  // Sequencer next-state: issue a coin, wait for the vend flags, time the pulses.
  always_comb begin
    state_s     = state_r;
    pulse_cnt_s = pulse_cnt_r;
    chg_pend_s  = chg_pend_r;
    code_s      = 2'b00;
    sale_inc_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (pop_s) begin
          code_s  = head_s;
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        state_s = WAIT;
      end
      WAIT: begin
        if (vm_d_out) begin
          chg_pend_s  = vm_d_c;
          pulse_cnt_s = PULSE_V;
          state_s     = DISPENSE;
        end else begin
          state_s = IDLE;
        end
      end
      DISPENSE: begin
        if (pulse_cnt_r <= 8'd1) begin
          if (chg_pend_r) begin
            pulse_cnt_s = PULSE_V;
            state_s     = CHANGE;
          end else begin
            sale_inc_s = 1'b1;
            state_s    = IDLE;
          end
        end else begin
          pulse_cnt_s = pulse_cnt_r - 8'd1;
        end
      end
      CHANGE: begin
        if (pulse_cnt_r <= 8'd1) begin
          sale_inc_s = 1'b1;
          state_s    = IDLE;
        end else begin
          pulse_cnt_s = pulse_cnt_r - 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= IDLE;
      pulse_cnt_r <= 8'd0;
      chg_pend_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      pulse_cnt_r <= pulse_cnt_s;
      chg_pend_r  <= chg_pend_s;
    end
  end

  // Outputs are registered from next-state so each lines up with its state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vm_d_in  <= 2'b00;
      motor    <= 1'b0;
      hopper   <= 1'b0;
      busy     <= 1'b0;
      rej_a    <= 1'b0;
      rej_b    <= 1'b0;
      sale_cnt <= {CNT_W{1'b0}};
    end else begin
      vm_d_in  <= code_s;
      motor    <= (state_s == DISPENSE);
      hopper   <= (state_s == CHANGE);
      busy     <= (state_s != IDLE);
      rej_a    <= rej_a_s;
      rej_b    <= rej_b_s;
      sale_cnt <= sale_cnt + CNT_W'(sale_inc_s);
    end
  end

endmodule

// File: tb/tb_vm_coin_sched.sv
// Directed self-checking bench for vm_coin_sched. A second instance with a
// 2-bit sale counter runs on the same stimulus to exercise counter wrap.
module tb_vm_coin_sched;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] coin_a;
  logic       coin_a_stb;
  logic [1:0] coin_b;
  logic       coin_b_stb;
  logic       vm_d_out = 1'b0;
  logic       vm_d_c   = 1'b0;

  logic       rej_a, rej_b, motor, hopper, busy;
  logic [1:0] vm_d_in;
  logic [7:0] sale_cnt;
  logic       rej_a2, rej_b2, motor2, hopper2, busy2;
  logic [1:0] vm_d_in2;
  logic [1:0] sale_cnt2;

  logic vend_en = 1'b0;
  logic chg_en  = 1'b0;
  logic prev_issue = 1'b0;

  logic [1:0] issued_q [$];
  int         rej_seen = 0;
  int         mirror_diff = 0;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  vm_coin_sched #(.PULSE_CYC(8), .FIFO_DEPTH(4), .CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .coin_a(coin_a), .coin_a_stb(coin_a_stb),
    .coin_b(coin_b), .coin_b_stb(coin_b_stb),
    .rej_a(rej_a), .rej_b(rej_b), .vm_d_in(vm_d_in),
    .vm_d_out(vm_d_out), .vm_d_c(vm_d_c),
    .motor(motor), .hopper(hopper), .busy(busy), .sale_cnt(sale_cnt)
  );

  vm_coin_sched #(.PULSE_CYC(8), .FIFO_DEPTH(4), .CNT_W(2)) dut_w2 (
    .Clk(Clk), .Reset(Reset),
    .coin_a(coin_a), .coin_a_stb(coin_a_stb),
    .coin_b(coin_b), .coin_b_stb(coin_b_stb),
    .rej_a(rej_a2), .rej_b(rej_b2), .vm_d_in(vm_d_in2),
    .vm_d_out(vm_d_out), .vm_d_c(vm_d_c),
    .motor(motor2), .hopper(hopper2), .busy(busy2), .sale_cnt(sale_cnt2)
  );

  // Vending-FSM model plus monitors: flags answer in the cycle after a coin is shown.
  always @(negedge Clk) begin
    vm_d_out   = prev_issue & vend_en;
    vm_d_c     = prev_issue & chg_en;
    prev_issue = (vm_d_in != 2'b00);
    if (vm_d_in != 2'b00) issued_q.push_back(vm_d_in);
    if (rej_a || rej_b) rej_seen++;
    if ({rej_a, rej_b, vm_d_in, motor, hopper, busy} !==
        {rej_a2, rej_b2, vm_d_in2, motor2, hopper2, busy2}) mirror_diff++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic sa, input logic [1:0] ca, input logic sb, input logic [1:0] cb);
    coin_a_stb = sa; coin_a = ca;
    coin_b_stb = sb; coin_b = cb;
  endtask

  task automatic check_issued(input string tag, input int base, input logic [1:0] exp [5], input int n);
    check_eq({tag, "_cnt"}, issued_q.size() - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < issued_q.size())
        check_eq($sformatf("%s_%0d", tag, i), {30'd0, issued_q[base + i]}, {30'd0, exp[i]});
    end
  endtask

  logic [1:0] exp_q [5];
  logic [1:0] wrap_exp [5];
  int base;
  int rbase;

  initial begin
    Reset = 1'b1;
    strobe(1'b0, 2'b00, 1'b0, 2'b00);
    ticks(2);
    check_eq("reset_outs", {26'd0, vm_d_in, motor, hopper, busy, rej_a, rej_b}, 32'd0);
    check_eq("reset_sale", {24'd0, sale_cnt}, 32'd0);
    Reset = 1'b0;
    tick();

    // Single coin, FSM model declines the vend
    strobe(1'b1, 2'b01, 1'b0, 2'b00);
    tick();                                   // t+1
    strobe(1'b0, 2'b00, 1'b0, 2'b00);
    check_eq("single_t1_din", {30'd0, vm_d_in}, 32'd0);
    check_eq("single_t1_busy", {31'd0, busy}, 32'd0);
    tick();                                   // t+2
    check_eq("single_t2_din", {30'd0, vm_d_in}, 32'd1);
    check_eq("single_t2_busy", {31'd0, busy}, 32'd1);
    tick();                                   // t+3
    check_eq("single_t3_din", {30'd0, vm_d_in}, 32'd0);
    check_eq("single_t3_motor", {31'd0, motor}, 32'd0);
    tick();                                   // t+4
    check_eq("single_t4", {29'd0, busy, motor, hopper}, 32'd0);

    // Vend with change, PULSE_CYC = 8
    vend_en = 1'b1; chg_en = 1'b1;
    strobe(1'b0, 2'b00, 1'b1, 2'b10);
    tick();
    strobe(1'b0, 2'b00, 1'b0, 2'b00);
    tick();                                   // t+2
    check_eq("chg_issue_din", {30'd0, vm_d_in}, 32'd2);
    tick();                                   // t+3
    check_eq("chg_wait_motor", {31'd0, motor}, 32'd0);
    tick();                                   // t+4
    vend_en = 1'b0; chg_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("motor_win_%0d", i), {30'd0, motor, hopper}, 32'd2);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("hopper_win_%0d", i), {30'd0, motor, hopper}, 32'd1);
      if (i == 7) check_eq("sale_before_end", {24'd0, sale_cnt}, 32'd0);
      tick();
    end
    check_eq("chg_end", {29'd0, motor, hopper, busy}, 32'd0);
    check_eq("chg_sale", {24'd0, sale_cnt}, 32'd1);

    // Conflict with one free entry, slot A preferred
    base = issued_q.size();
    vend_en = 1'b1;
    strobe(1'b1, 2'b10, 1'b0, 2'b00);         // t0: vending coin
    tick();
    strobe(1'b0, 2'b00, 1'b0, 2'b00);
    ticks(3);                                 // t0+4, in DISPENSE
    vend_en = 1'b0;
    strobe(1'b1, 2'b01, 1'b0, 2'b00); tick();
    strobe(1'b1, 2'b10, 1'b0, 2'b00); tick();
    strobe(1'b1, 2'b01, 1'b0, 2'b00); tick(); // t0+7: FIFO at 3
    strobe(1'b1, 2'b10, 1'b1, 2'b01); tick(); // t0+8
    check_eq("conf1_rej", {30'd0, rej_a, rej_b}, 32'd1);
    strobe(1'b1, 2'b01, 1'b0, 2'b00); tick(); // t0+9: FIFO full
    strobe(1'b0, 2'b00, 1'b0, 2'b00);
    check_eq("full_rej_a", {31'd0, rej_a}, 32'd1);
    ticks(3);                                 // t0+12: FSM pops this cycle
    check_eq("conf1_sale", {24'd0, sale_cnt}, 32'd2);
    strobe(1'b1, 2'b01, 1'b0, 2'b00); tick(); // t0+13
    check_eq("full_pop_rej_a", {31'd0, rej_a}, 32'd1);
    strobe(1'b1, 2'b11, 1'b0, 2'b00); tick(); // t0+14
    strobe(1'b0, 2'b00, 1'b0, 2'b00);
    check_eq("code11_rej_a", {30'd0, rej_a, rej_b}, 32'd2);
    ticks(14);
    check_eq("conf1_idle", {31'd0, busy}, 32'd0);
    exp_q = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    check_issued("conf1_order", base, exp_q, 5);

    // Conflict again after drain: slot B now preferred
    base = issued_q.size();
    vend_en = 1'b1;
    strobe(1'b1, 2'b10, 1'b0, 2'b00);
    tick();
    strobe(1'b0, 2'b00, 1'b0, 2'b00);
    ticks(3);
    vend_en = 1'b0;
    strobe(1'b0, 2'b00, 1'b1, 2'b10); tick();
    strobe(1'b0, 2'b00, 1'b1, 2'b10); tick();
    strobe(1'b1, 2'b01, 1'b0, 2'b00); tick();
    strobe(1'b1, 2'b01, 1'b1, 2'b10); tick();
    strobe(1'b0, 2'b00, 1'b0, 2'b00);
    check_eq("conf2_rej", {30'd0, rej_a, rej_b}, 32'd2);
    ticks(20);
    check_eq("conf2_sale", {24'd0, sale_cnt}, 32'd3);
    exp_q = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
    check_issued("conf2_order", base, exp_q, 5);

    // Conflict with room for both: preferred slot (A again) goes first
    base = issued_q.size();
    strobe(1'b1, 2'b10, 1'b1, 2'b01); tick();
    strobe(1'b0, 2'b00, 1'b0, 2'b00);
    check_eq("both_no_rej", {30'd0, rej_a, rej_b}, 32'd0);
    ticks(7);
    exp_q = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
    check_issued("both_order", base, exp_q, 2);

    // Reset in the middle of a vend with two coins queued
    vend_en = 1'b1;
    strobe(1'b1, 2'b10, 1'b0, 2'b00); tick();
    strobe(1'b0, 2'b00, 1'b0, 2'b00);
    ticks(3);                                 // r0+4
    vend_en = 1'b0;
    strobe(1'b0, 2'b00, 1'b1, 2'b01); tick();
    strobe(1'b0, 2'b00, 1'b1, 2'b10); tick();
    strobe(1'b0, 2'b00, 1'b0, 2'b00); tick(); // r0+7
    check_eq("midvend_motor", {31'd0, motor}, 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_eq("midrst_outs", {26'd0, vm_d_in, motor, hopper, busy, rej_a, rej_b}, 32'd0);
    check_eq("midrst_sale", {24'd0, sale_cnt}, 32'd0);
    base  = issued_q.size();
    rbase = rej_seen;
    ticks(20);
    check_eq("midrst_no_issue", issued_q.size() - base, 32'd0);
    check_eq("midrst_no_rej", rej_seen - rbase, 32'd0);
    check_eq("midrst_idle", {31'd0, busy}, 32'd0);

    // Five vends: 2-bit counter wraps
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    vend_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      strobe(1'b1, 2'b01, 1'b0, 2'b00); tick();
      strobe(1'b0, 2'b00, 1'b0, 2'b00);
      ticks(11);
      check_eq($sformatf("wrap_cnt2_%0d", k), {30'd0, sale_cnt2}, {30'd0, wrap_exp[k]});
      check_eq($sformatf("wrap_cnt8_%0d", k), {24'd0, sale_cnt}, k + 1);
    end
    vend_en = 1'b0;
    check_eq("mirror_diff", mirror_diff, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
